// File: rtl/dac_spi_frame_scheduler_if.sv
// Request/pin bundle for the shared DAC SPI scheduler; drop_count exists only with DAC_SCHED_DROP_CNT_EN.
interface dac_spi_frame_scheduler_if #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 16
);
   localparam int CH_W = $clog2(N_CH);

   logic [N_CH-1:0]        en;
   logic [N_CH-1:0]        req_valid;
   logic [N_CH*DATA_W-1:0] req_data;
   logic [N_CH-1:0]        DAC_SYNC;
   logic                   DAC_SCLK;
   logic                   DAC_DIN;
   logic                   busy;
   logic [CH_W-1:0]        ch_active;
   logic [N_CH-1:0]        pending;
   logic                   frame_done;
`ifdef DAC_SCHED_DROP_CNT_EN
   logic [15:0]            drop_count;

   modport master (output en, req_valid, req_data,
                   input  DAC_SYNC, DAC_SCLK, DAC_DIN, busy, ch_active, pending, frame_done, drop_count);
   modport slave  (input  en, req_valid, req_data,
                   output DAC_SYNC, DAC_SCLK, DAC_DIN, busy, ch_active, pending, frame_done, drop_count);
`else
   modport master (output en, req_valid, req_data,
                   input  DAC_SYNC, DAC_SCLK, DAC_DIN, busy, ch_active, pending, frame_done);
   modport slave  (input  en, req_valid, req_data,
                   output DAC_SYNC, DAC_SCLK, DAC_DIN, busy, ch_active, pending, frame_done);
`endif
endinterface

// File: rtl/dac_spi_frame_scheduler.sv
// Round-robin scheduler sharing one SPI shifter among N_CH DACs: 24-bit frames {8'h00, sample}, MSB first.
// Optional DAC_SCHED_DROP_CNT_EN adds a saturating drop counter (overwrites and disabled-channel requests).
module dac_spi_frame_scheduler #(
   parameter int N_CH     = 8,
   parameter int DATA_W   = 16,
   parameter int SCLK_DIV = 1,
   parameter int GAP_CYC  = 2
) (
   input  logic                       dataclk,
   input  logic                       reset,
   dac_spi_frame_scheduler_if.slave   bus
);
   localparam int FRAME_W = DATA_W + 8;
   localparam int CH_W    = $clog2(N_CH);
   localparam int DIV_W   = $clog2(SCLK_DIV + 1);
   localparam int GAP_W   = $clog2(GAP_CYC + 1);
   localparam int BIT_W   = $clog2(FRAME_W);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t                       state_q, state_d;
   logic [N_CH-1:0]              pending_q, pending_d;
   logic [N_CH-1:0][DATA_W-1:0]  data_buf_q, data_buf_d;
   logic [FRAME_W-1:0]           shreg_q, shreg_d;
   logic [N_CH-1:0]              sync_q, sync_d;
   logic                         sclk_q, sclk_d;
   logic                         din_q, din_d;
   logic                         busy_q, busy_d;
   logic                         frame_done_q, frame_done_d;
   logic [CH_W-1:0]              ch_q, ch_d;
   logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]             gap_cnt_q, gap_cnt_d;
`ifdef DAC_SCHED_DROP_CNT_EN
   logic [15:0]                  drop_cnt_q, drop_cnt_d;
`endif

   logic [N_CH-1:0][DATA_W-1:0]  req_dat;
   logic                         grant_vld;
   logic [CH_W-1:0]              grant_idx;
   logic [CH_W-1:0]              scan_idx;
   logic [FRAME_W-1:0]           frame_dat;
   logic                         granting;

   assign req_dat  = bus.req_data;
   assign granting = (state_q == IDLE) && grant_vld;

   // Scan downward so the last hit is the nearest channel above rr_ptr.
   always_comb begin
      grant_vld = |pending_q;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = N_CH; k >= 1; k--) begin
         scan_idx = CH_W'((int'(rr_ptr_q) + k) % N_CH);
         if (pending_q[scan_idx]) grant_idx = scan_idx;
      end
   end

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      data_buf_d   = data_buf_q;
      shreg_d      = shreg_q;
      sync_d       = sync_q;
      sclk_d       = sclk_q;
      din_d        = din_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      ch_d         = ch_q;
      rr_ptr_d     = rr_ptr_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      frame_dat    = {8'h00, data_buf_q[grant_idx]};

      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               ch_d                 = grant_idx;
               rr_ptr_d             = grant_idx;
               shreg_d              = frame_dat;
               pending_d[grant_idx] = 1'b0;
               sync_d               = '1;
               sync_d[grant_idx]    = 1'b0;
               din_d                = frame_dat[FRAME_W-1];
               sclk_d               = 1'b0;
               busy_d               = 1'b1;
               div_cnt_d            = '0;
               bit_cnt_d            = '0;
               state_d              = SHIFT;
            end
         end
         SHIFT: begin
            if (div_cnt_q == DIV_W'(SCLK_DIV - 1)) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  din_d   = shreg_q[FRAME_W-1];
                  shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                     sync_d       = '1;
                     frame_done_d = 1'b1;
                     gap_cnt_d    = '0;
                     state_d      = GAP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Applied after the grant so a same-cycle request re-arms the granted channel.
      for (int i = 0; i < N_CH; i++) begin
         if (bus.req_valid[i] && bus.en[i]) begin
            pending_d[i]  = 1'b1;
            data_buf_d[i] = req_dat[i];
         end else if (!bus.en[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

`ifdef DAC_SCHED_DROP_CNT_EN
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      for (int i = 0; i < N_CH; i++) begin
         if (bus.req_valid[i] && (!bus.en[i] ||
             (pending_q[i] && !(granting && grant_idx == CH_W'(i))))) begin
            if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
         end
      end
   end
`endif

   always_ff @(posedge dataclk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         data_buf_q   <= '0;
         shreg_q      <= '0;
         sync_q       <= '1;
         sclk_q       <= 1'b0;
         din_q        <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         ch_q         <= '0;
         rr_ptr_q     <= CH_W'(N_CH - 1);
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
`ifdef DAC_SCHED_DROP_CNT_EN
         drop_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         data_buf_q   <= data_buf_d;
         shreg_q      <= shreg_d;
         sync_q       <= sync_d;
         sclk_q       <= sclk_d;
         din_q        <= din_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         ch_q         <= ch_d;
         rr_ptr_q     <= rr_ptr_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
`ifdef DAC_SCHED_DROP_CNT_EN
         drop_cnt_q   <= drop_cnt_d;
`endif
      end
   end

   assign bus.DAC_SYNC   = sync_q;
   assign bus.DAC_SCLK   = sclk_q;
   assign bus.DAC_DIN    = din_q;
   assign bus.busy       = busy_q;
   assign bus.ch_active  = ch_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = frame_done_q;
`ifdef DAC_SCHED_DROP_CNT_EN
   assign bus.drop_count = drop_cnt_q;
`endif
endmodule
